// File: rtl/ahbl_i2s_rx_fifo_if.sv
// AHB-Lite slave-side bus bundle for the I2S receiver.
// The master modport is the bus side; the slave modport is the peripheral side.
interface ahbl_i2s_rx_fifo_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HWRITE, HADDR, HTRANS, HSIZE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HWRITE, HADDR, HTRANS, HSIZE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahbl_i2s_rx_fifo.sv
// AHB-Lite I2S microphone receiver: generates SCK/WS, captures SAMPLE_W-bit slots
// and buffers them in a FIFO with level and overrun interrupts.
module ahbl_i2s_rx_fifo #(
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahbl_i2s_rx_fifo_if.slave bus,
  input  logic              SD,
  output logic              SCK,
  output logic              WS,
  output logic              IRQ
);
  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW    = PtrW + 1;
  localparam logic [4:0]  LastBit = 5'(SAMPLE_W);

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrPresc  = 8'h04;
  localparam logic [7:0] AddrStatus = 8'h08;
  localparam logic [7:0] AddrData   = 8'h0C;
  localparam logic [7:0] AddrThresh = 8'h10;
  localparam logic [7:0] AddrIm     = 8'h14;

  logic [7:0]          addr_q;
  logic                wr_q, rd_q;
  logic                en_q, sext_q, ovr_q, irq_q;
  logic [1:0]          chmode_q, im_q;
  logic [7:0]          presc_q;
  logic [6:0]          thresh_q;
  logic [7:0]          div_q;
  logic                sck_q;
  logic [5:0]          bit_q;
  logic [SAMPLE_W-1:0] shift_q, push_data_q;
  logic                push_q;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [LvlW-1:0]     level_q;

  logic wr_ctrl, wr_presc, wr_status, wr_thresh, wr_im, flush;
  logic tc, rise, fall, slot_en;
  logic empty, full, pop, do_push, ovr_set;
  logic [6:0] level7;
  logic [SAMPLE_W-1:0] head;
  logic [31:0] head_ext;
  logic unused_bits;

  assign unused_bits = ^{bus.HADDR[31:8], bus.HTRANS[0], bus.HSIZE, bus.HWDATA[31:8]};

  // Address phase is captured here; the access itself happens in the next cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      wr_q <= bus.HREADY & bus.HSEL & bus.HTRANS[1] & bus.HWRITE;
      rd_q <= bus.HREADY & bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
      if (bus.HREADY) addr_q <= bus.HADDR[7:0];
    end
  end

  assign wr_ctrl   = wr_q & (addr_q == AddrCtrl);
  assign wr_presc  = wr_q & (addr_q == AddrPresc);
  assign wr_status = wr_q & (addr_q == AddrStatus);
  assign wr_thresh = wr_q & (addr_q == AddrThresh);
  assign wr_im     = wr_q & (addr_q == AddrIm);
  assign flush     = wr_ctrl & bus.HWDATA[4];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q     <= 1'b0;
      chmode_q <= '0;
      sext_q   <= 1'b0;
      presc_q  <= '0;
      thresh_q <= '0;
      im_q     <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= bus.HWDATA[0];
        chmode_q <= bus.HWDATA[2:1];
        sext_q   <= bus.HWDATA[3];
      end
      if (wr_presc && !en_q) presc_q <= bus.HWDATA[7:0];
      if (wr_thresh) thresh_q <= bus.HWDATA[6:0];
      if (wr_im) im_q <= bus.HWDATA[1:0];
      // A fresh overrun beats a concurrent write-1-to-clear.
      if (ovr_set) ovr_q <= 1'b1;
      else if (wr_status && bus.HWDATA[2]) ovr_q <= 1'b0;
      irq_q <= (im_q[0] & (level7 >= thresh_q) & (thresh_q != '0)) | (im_q[1] & ovr_q);
    end
  end

  assign tc   = (div_q == presc_q);
  assign rise = en_q & tc & ~sck_q;
  assign fall = en_q & tc & sck_q;

  always_comb begin
    case (chmode_q)
      2'b01:   slot_en = bit_q[5];
      2'b10:   slot_en = 1'b1;
      default: slot_en = ~bit_q[5];
    endcase
  end

  // Slot bit 0 carries the previous slot's trailing bit, so capture starts at bit 1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      if (!en_q) begin
        div_q   <= '0;
        sck_q   <= 1'b0;
        bit_q   <= '0;
        shift_q <= '0;
      end else begin
        div_q <= tc ? 8'd0 : div_q + 8'd1;
        if (tc) sck_q <= ~sck_q;
        if (fall) bit_q <= bit_q + 6'd1;
        if (rise && (bit_q[4:0] != 5'd0) && (bit_q[4:0] <= LastBit)) begin
          shift_q <= {shift_q[SAMPLE_W-2:0], SD};
        end
      end
      push_q      <= rise & (bit_q[4:0] == LastBit) & slot_en;
      push_data_q <= {shift_q[SAMPLE_W-2:0], SD};
    end
  end

  assign level7  = 7'(level_q);
  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign pop     = rd_q & (addr_q == AddrData) & ~empty;
  assign do_push = push_q & (~full | pop) & ~flush;
  assign ovr_set = push_q & full & ~pop & ~flush;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !pop) level_q <= level_q + LvlW'(1);
      else if (pop && !do_push) level_q <= level_q - LvlW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wptr_q] <= push_data_q;
  end

  assign head     = mem_q[rptr_q];
  assign head_ext = empty ? 32'd0 : {{(32 - SAMPLE_W){sext_q & head[SAMPLE_W-1]}}, head};

  always_comb begin
    case (addr_q)
      AddrCtrl:   bus.HRDATA = {28'd0, sext_q, chmode_q, en_q};
      AddrPresc:  bus.HRDATA = {24'd0, presc_q};
      AddrStatus: bus.HRDATA = {17'd0, level7, 5'd0, ovr_q, full, empty};
      AddrData:   bus.HRDATA = head_ext;
      AddrThresh: bus.HRDATA = {25'd0, thresh_q};
      AddrIm:     bus.HRDATA = {30'd0, im_q};
      default:    bus.HRDATA = 32'hBADD_BEEF;
    endcase
  end

  assign bus.HREADYOUT = 1'b1;
  assign SCK = sck_q;
  assign WS  = bit_q[5];
  assign IRQ = irq_q;
endmodule
